// File: rtl/seq_dispatcher.sv
// rtl/seq_dispatcher.sv - command FIFO and program launcher feeding the sequencer
module seq_dispatcher #(
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PARK  = 0,
    parameter int unsigned TMO   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              cmd_addr,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       abort,
    input  logic                       seq_stop,
    output logic [AW-1:0]              seq_addr,
    output logic                       seq_jump,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TMO);
    localparam logic [AW-1:0] PARK_A = AW'(PARK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RUN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic [AW-1:0]   addr_d;
    logic            jump_d;
    logic            done_d;
    logic            pop;
    logic            push;
    logic            drop;
    logic            full;
    logic [CW-1:0]   count_d;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   mem [DEPTH];

    // Abort swallows any same-cycle push; a push into a full queue is dropped.
    assign full = (count == CW'(DEPTH));
    assign push = cmd_valid && !abort && !full;
    assign drop = cmd_valid && !abort && full;

    // Launcher next-state: abort forces a jump to PARK, otherwise walk the program lifecycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        addr_d  = seq_addr;
        jump_d  = 1'b0;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (abort) begin
            addr_d  = PARK_A;
            jump_d  = 1'b1;
            state_d = S_LAUNCH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // count only reflects entries written on earlier cycles, so no bypass
                    if (count != '0 && seq_stop) begin
                        pop     = 1'b1;
                        addr_d  = mem[rd_ptr];
                        jump_d  = 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (!seq_stop) begin
                        state_d = S_RUN;
                    end else if (timer_q == TW'(TMO - 1)) begin
                        // program began on a STOP opcode and never ran
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_RUN: begin
                    if (seq_stop) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Queue occupancy after this cycle's push, pop or flush.
    always_comb begin
        count_d = count;
        if (abort) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (pop && !push) begin
            count_d = count - CW'(1);
        end
    end

    // Control registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            seq_addr  <= PARK_A;
            seq_jump  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_addr  <= addr_d;
            seq_jump  <= jump_d;
            done      <= done_d;
            busy      <= (state_d != S_IDLE);
            count     <= count_d;
            cmd_ready <= (count_d < CW'(DEPTH));
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_addr;
    end

endmodule

// File: tb/tb_seq_dispatcher.sv
// tb/tb_seq_dispatcher.sv - directed and random checks of seq_dispatcher against a queue model
module tb_seq_dispatcher;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int PARK  = 0;
    localparam int TMO   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          abort = 1'b0;
    logic          seq_stop = 1'b1;
    logic [AW-1:0] seq_addr;
    logic          seq_jump;
    logic          busy;
    logic          done;
    logic [2:0]    count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    seq_dispatcher #(.AW(AW), .DEPTH(DEPTH), .PARK(PARK), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_addr  (cmd_addr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .seq_stop  (seq_stop),
        .seq_addr  (seq_addr),
        .seq_jump  (seq_jump),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: pending programs as a queue plus the lifecycle phase of the current one.
    typedef enum int {P_IDLE, P_LAUNCH, P_WAIT, P_RUN} phase_t;
    int     mq[$];
    phase_t m_phase;
    int     m_wait;
    int     m_addr;
    bit     m_jump, m_done, m_ovf;

    int jlog[$];
    int dcnt = 0;

    function automatic void model_reset();
        mq.delete();
        m_phase = P_IDLE;
        m_wait  = 0;
        m_addr  = PARK;
        m_jump  = 0;
        m_done  = 0;
        m_ovf   = 0;
    endfunction

    function automatic void model_step(bit v, int a, bit ab, bit st);
        int sz = mq.size();
        m_jump = 0;
        m_done = 0;
        if (ab) begin
            mq.delete();
            m_addr  = PARK;
            m_jump  = 1;
            m_phase = P_LAUNCH;
            return;
        end
        case (m_phase)
            P_IDLE: if (sz > 0 && st) begin
                m_addr  = mq.pop_front();
                m_jump  = 1;
                m_phase = P_LAUNCH;
            end
            P_LAUNCH: begin
                m_wait  = 1;
                m_phase = P_WAIT;
            end
            P_WAIT: begin
                if (!st) m_phase = P_RUN;
                else if (m_wait == TMO) begin
                    m_done  = 1;
                    m_phase = P_IDLE;
                end else m_wait++;
            end
            P_RUN: if (st) begin
                m_done  = 1;
                m_phase = P_IDLE;
            end
        endcase
        if (v) begin
            if (sz < DEPTH) mq.push_back(a);
            else m_ovf = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("addr",     32'(seq_addr),  32'(m_addr));
        chk("jump",     32'(seq_jump),  32'(m_jump));
        chk("done",     32'(done),      32'(m_done));
        chk("busy",     32'(busy),      32'(m_phase != P_IDLE));
        chk("count",    32'(count),     32'(mq.size()));
        chk("ready",    32'(cmd_ready), 32'(mq.size() < DEPTH));
        chk("overflow", 32'(overflow),  32'(m_ovf));
        chk("excl",     32'(done && seq_jump), 32'(0));
    endtask

    task automatic step(input bit v, input int a, input bit ab, input bit st);
        cmd_valid = v;
        cmd_addr  = AW'(a);
        abort     = ab;
        seq_stop  = st;
        model_step(v, a, ab, st);
        @(posedge clk);
        #1;
        if (seq_jump === 1'b1) jlog.push_back(int'(seq_addr));
        if (done === 1'b1) dcnt++;
        chk_model();
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_addr",  32'(seq_addr),  32'(0));
        chk("rst_jump",  32'(seq_jump),  32'(0));
        chk("rst_busy",  32'(busy),      32'(0));
        chk("rst_count", 32'(count),     32'(0));
        chk("rst_ready", 32'(cmd_ready), 32'(1));
        chk_model();
        rst = 1'b0;
    endtask

    initial begin
        int jmark;
        int dmark;
        bit st_r;

        // 1 reset
        do_reset();

        // 2 single launch
        step(1, 2, 0, 1);
        step(0, 0, 0, 1);
        chk("t2_jump", 32'(seq_jump), 32'(1));
        chk("t2_addr", 32'(seq_addr), 32'(2));
        chk("t2_busy", 32'(busy), 32'(1));
        step(0, 0, 0, 1);
        chk("t2_jump_off", 32'(seq_jump), 32'(0));
        dmark = dcnt;
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("t2_done", 32'(done), 32'(1));
        chk("t2_idle", 32'(busy), 32'(0));
        step(0, 0, 0, 1);
        chk("t2_done_cnt", 32'(dcnt - dmark), 32'(1));

        // 3 queue order, pushed while the sequencer is still running
        step(1, 2, 0, 0);
        step(1, 12, 0, 0);
        step(1, 19, 0, 0);
        chk("t3_count3", 32'(count), 32'(3));
        jmark = jlog.size();
        for (int p = 0; p < 3; p++) begin
            step(0, 0, 0, 1);
            chk("t3_count", 32'(count), 32'(2 - p));
            step(0, 0, 0, 1);
            repeat (3) step(0, 0, 0, 0);
            step(0, 0, 0, 1);
        end
        chk("t3_njump", 32'(jlog.size() - jmark), 32'(3));
        if (jlog.size() - jmark == 3) begin
            chk("t3_ord0", 32'(jlog[jmark]),     32'(2));
            chk("t3_ord1", 32'(jlog[jmark + 1]), 32'(12));
            chk("t3_ord2", 32'(jlog[jmark + 2]), 32'(19));
        end

        // 4 full queue and sticky overflow
        step(1, 7, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
        chk("t4_ready", 32'(cmd_ready), 32'(0));
        chk("t4_count", 32'(count), 32'(4));
        chk("t4_ovf", 32'(overflow), 32'(1));
        for (int k = 0; k < 40; k++) step(0, 0, 0, (k % 4) != 0);
        chk("t4_drained", 32'(count), 32'(0));
        chk("t4_ovf_sticky", 32'(overflow), 32'(1));

        // 5 program that starts on STOP
        step(1, 0, 0, 1);
        step(1, 9, 0, 1);
        repeat (14) step(0, 0, 0, 1);
        chk("t5_last0", 32'(jlog[jlog.size() - 2]), 32'(0));
        chk("t5_last9", 32'(jlog[jlog.size() - 1]), 32'(9));

        // 6 abort while 19 runs with three queued
        step(1, 19, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        dmark = dcnt;
        step(1, 25, 1, 0);
        chk("t6_count", 32'(count), 32'(0));
        chk("t6_addr", 32'(seq_addr), 32'(0));
        chk("t6_jump", 32'(seq_jump), 32'(1));
        repeat (8) step(0, 0, 0, 1);
        chk("t6_one_done", 32'(dcnt - dmark), 32'(1));
        chk("t6_no25", 32'(count), 32'(0));

        // reset while seq_jump is high
        step(1, 4, 0, 1);
        step(0, 0, 0, 1);
        chk("rl_jump", 32'(seq_jump), 32'(1));
        do_reset();

        // random traffic
        st_r = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) st_r = ~st_r;
            step($urandom_range(1) == 1, int'($urandom_range(31)),
                 $urandom_range(49) == 0, st_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
